muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Sequences RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) in the execute stage.
//  Latches operands, runs a fixed-latency multiply or a radix-2 restoring divide
//  (one quotient bit per cycle), and stalls the pipeline until the result is ready.
//  Sits beside the ALU; the EX result mux selects result when result_valid=1.
// PARAMETERS
//  XLEN         32  operand/result width; also the divide iteration count
//  MUL_LATENCY  2   cycles spent in MUL state (>=1), models a multi-cycle multiplier path
// PORTS
//  clk           in   1     clock, rising edge
//  rst_n         in   1     synchronous reset, active low
//  start         in   1     M-ext instr valid in EX (opcode 0110011, func7 0000001); held while stall=1
//  flush         in   1     kill in-flight op (branch mispredict / trap)
//  func3         in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  op_a          in   XLEN  rs1 value (dividend / multiplicand)
//  op_b          in   XLEN  rs2 value (divisor / multiplier)
//  stall         out  1     freeze IF/ID/EX; combinational
//  result        out  XLEN  registered result
//  result_valid  out  1     registered one-cycle pulse; result is valid this cycle
// BEHAVIOUR
//  Reset: state=IDLE, result=0, result_valid=0, counters/operand regs=0; stall=0 while rst_n=0.
//  States: IDLE, MUL, DIV, DONE.
//   IDLE: start&!flush -> latch func3/op_a/op_b; func3[2]=0 -> MUL (cnt=MUL_LATENCY-1), else -> DIV (cnt=XLEN-1).
//   MUL: full 2*XLEN product registered on entry (signedness per func3); cnt==0 -> DONE, else cnt--.
//   DIV: operate on |a|,|b| for signed ops; each cycle shift rem, trial subtract, set quotient bit;
//        cnt==0 -> DONE. Sign fixup: quotient negated if signs differ; remainder takes dividend sign.
//   DONE: result_valid=1, stall=0, result holds selected value; unconditionally -> IDLE.
//  stall = (state==MUL)|(state==DIV)|(state==IDLE & start & !flush).
//  Latency (start first seen in IDLE = cycle 0): MUL result_valid in cycle MUL_LATENCY+1;
//   DIV result_valid in cycle XLEN+1. Stall high cycles 0..latency-1.
//  Result select: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits; DIV/DIVU quotient; REM/REMU rem.
//  start ignored outside IDLE (operands already latched); op_a/op_b changes after accept have no effect.
//  Back-to-back: pipeline advances at end of DONE; next op accepted in the following IDLE cycle.
//  Divide by zero: quotient=all ones (DIV and DIVU), remainder=dividend.
//  Signed overflow (DIV/REM, a=-2^(XLEN-1), b=-1): quotient=a, remainder=0.
//  flush: any state -> IDLE next edge, no result_valid, result unchanged; flush wins over start
//   in the same cycle. Flush during DONE suppresses nothing (pulse already output that cycle).
//  rst_n low in any state overrides flush/start; state returns to IDLE on that edge.
//  result_valid never asserted in two consecutive cycles.
// CONFIGURATION
//  MULDIV_DIV_FASTPATH_EN defined: divide-by-zero and signed overflow detected in IDLE at accept;
//   skip DIV, go straight to DONE (result_valid in cycle 1, stall high cycle 0 only).
//  Not defined: these cases run all XLEN iterations; special values forced at DIV->DONE;
//   latency identical to a normal divide (XLEN+1).
// TESTING
//  MUL 7 * 0xFFFFFFFD (-3), MUL_LATENCY=2 -> result 0xFFFFFFEB, result_valid in cycle 3, stall cycles 0-2.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU same -> 0x40000000; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD, cycle 33; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0;
//   valid in cycle 1 with MULDIV_DIV_FASTPATH_EN, cycle 33 without.
//  Flush at DIV iteration 10 -> IDLE next cycle, no result_valid; following DIVU 9/3 -> 3 in cycle 33.
//  rst_n low mid-MUL for one cycle -> IDLE, result=0, stall=0, no result_valid; start held -> reaccepted.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: EX-stage handshake between the pipeline and the RV32M sequencer
interface muldiv_sequencer_if #(parameter int XLEN = 32);
    logic            start;
    logic            flush;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            stall;
    logic [XLEN-1:0] result;
    logic            result_valid;
    modport master (output start, flush, func3, op_a, op_b, input stall, result, result_valid);
    modport slave  (input start, flush, func3, op_a, op_b, output stall, result, result_valid);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: RV32M multiply/divide sequencer; MULDIV_DIV_FASTPATH_EN enables the early-out for div-by-zero and signed overflow
module muldiv_sequencer #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input logic               clk,
    input logic               rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CMAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
    localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [1:0]        f3;
    logic [XLEN-1:0]   a, quo, rem, dvs;
    logic [2*XLEN-1:0] prod;
    logic              neg_q, neg_r, div0, ovf;

    logic              accept, sdiv_in, div0_in, ovf_in, fast, sa_m, sb_m, ge;
    logic [XLEN-1:0]   ma_in, mb_in, fast_res, q_n, r_n, q_fix, r_fix, mul_sel, div_sel;
    logic [XLEN:0]     trial, diff;
    logic [2*XLEN-1:0] ae, be, p_full;

    assign accept  = state == IDLE && bus.start && !bus.flush;
    assign sdiv_in = bus.func3[2] & ~bus.func3[0];
    assign ma_in   = (sdiv_in & bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
    assign mb_in   = (sdiv_in & bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
    assign div0_in = bus.op_b == '0;
    assign ovf_in  = sdiv_in && bus.op_a == {1'b1, {(XLEN-1){1'b0}}} && &bus.op_b;
    assign fast_res = bus.func3[1] ? (div0_in ? bus.op_a : '0) : (div0_in ? '1 : bus.op_a);

`ifdef MULDIV_DIV_FASTPATH_EN
    assign fast = bus.func3[2] & (div0_in | ovf_in);
`else
    assign fast = 1'b0;
`endif

    // MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed; MUL's low half is sign-agnostic
    assign sa_m   = bus.func3[1:0] != 2'b11 && bus.op_a[XLEN-1];
    assign sb_m   = bus.func3[1:0] == 2'b01 && bus.op_b[XLEN-1];
    assign ae     = {{XLEN{sa_m}}, bus.op_a};
    assign be     = {{XLEN{sb_m}}, bus.op_b};
    assign p_full = ae * be;

    // one restoring step: shift the next dividend bit into rem, keep the subtraction if it did not borrow
    assign trial = {rem, quo[XLEN-1]};
    assign diff  = trial - {1'b0, dvs};
    assign ge    = !diff[XLEN];
    assign q_n   = {quo[XLEN-2:0], ge};
    assign r_n   = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];

    assign q_fix   = div0 ? '1 : ovf ? a : (neg_q ? -q_n : q_n);
    assign r_fix   = div0 ? a : ovf ? '0 : (neg_r ? -r_n : r_n);
    assign div_sel = f3[1] ? r_fix : q_fix;
    assign mul_sel = f3 == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // next state and the combinational pipeline stall
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? (fast ? DONE : (bus.func3[2] ? DIV : MUL)) : IDLE;
            MUL:     nxt = cnt == '0 ? DONE : MUL;
            DIV:     nxt = cnt == '0 ? DONE : DIV;
            default: nxt = IDLE;
        endcase
        if (bus.flush) nxt = IDLE;
        bus.stall = rst_n & (state == MUL || state == DIV || accept);
    end

    // operand latch, iteration counter, divide datapath and registered result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt              <= '0;
            f3               <= '0;
            a                <= '0;
            quo              <= '0;
            rem              <= '0;
            dvs              <= '0;
            prod             <= '0;
            neg_q            <= 1'b0;
            neg_r            <= 1'b0;
            div0             <= 1'b0;
            ovf              <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
        end else begin
            bus.result_valid <= nxt == DONE;
            if (accept) begin
                f3    <= bus.func3[1:0];
                a     <= bus.op_a;
                prod  <= p_full;
                quo   <= ma_in;
                dvs   <= mb_in;
                rem   <= '0;
                neg_q <= sdiv_in & (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
                neg_r <= sdiv_in & bus.op_a[XLEN-1];
                div0  <= div0_in;
                ovf   <= ovf_in;
                cnt   <= bus.func3[2] ? CW'(XLEN - 1) : CW'(MUL_LATENCY - 1);
            end
            if (state == MUL || state == DIV) cnt <= cnt - CW'(1);
            if (state == DIV) begin
                quo <= q_n;
                rem <= r_n;
            end
            if (nxt == DONE) bus.result <= state == MUL ? mul_sel : state == DIV ? div_sel : fast_res;
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random RV32M ops checked against an arithmetic reference model
module tb_muldiv_sequencer;
    localparam int XLEN = 32;
    localparam int ML   = 2;
`ifdef MULDIV_DIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] last_res = '0;

    muldiv_sequencer_if #(.XLEN(XLEN)) bus ();
    muldiv_sequencer #(.XLEN(XLEN), .MUL_LATENCY(ML)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        bit o;
        sa = a;
        sb = b;
        o = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (f)
            3'd0: p = longint'({32'b0, a}) * longint'({32'b0, b});
            3'd1: p = longint'(sa) * longint'(sb);
            3'd2: p = longint'(sa) * longint'({32'b0, b});
            3'd3: p = longint'({32'b0, a}) * longint'({32'b0, b});
            default: p = '0;
        endcase
        if (f == 3'd0) return p[31:0];
        if (!f[2]) return p[63:32];
        if (f == 3'd4) return b == 0 ? 32'hFFFF_FFFF : o ? a : 32'(sa / sb);
        if (f == 3'd5) return b == 0 ? 32'hFFFF_FFFF : a / b;
        if (f == 3'd6) return b == 0 ? a : o ? 32'h0 : 32'(sa % sb);
        return b == 0 ? a : a % b;
    endfunction

    function automatic int lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit special;
        if (!f[2]) return ML + 1;
        special = b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (FAST && special) ? 1 : XLEN + 1;
    endfunction

    task automatic await_done(input logic [31:0] exp, input int exp_lat, input string tag);
        bit seen = 1'b0;
        for (int c = 1; c <= XLEN + 4 && !seen; c++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                seen = 1'b1;
                chk({tag, " latency"}, 32'(c), 32'(exp_lat));
                chk({tag, " result"}, bus.result, exp);
                chk({tag, " stall at done"}, {31'b0, bus.stall}, 32'd0);
            end else begin
                chk({tag, " stall busy"}, {31'b0, bus.stall}, 32'd1);
            end
            if (c == 1) begin
                bus.op_a = $urandom;
                bus.op_b = $urandom;
            end
        end
        chk({tag, " completed"}, {31'b0, seen}, 32'd1);
        last_res = exp;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = f;
        bus.op_a = a;
        bus.op_b = b;
        #1;
        chk({tag, " stall c0"}, {31'b0, bus.stall}, 32'd1);
        chk({tag, " no valid c0"}, {31'b0, bus.result_valid}, 32'd0);
        await_done(model(f, a, b), lat(f, a, b), tag);
    endtask

    initial begin
        logic [2:0] f;
        logic [31:0] a, b;
        bus.start = 1'b1;
        bus.flush = 1'b0;
        bus.func3 = 3'd0;
        bus.op_a = 32'd5;
        bus.op_b = 32'd6;
        repeat (3) @(negedge clk);
        chk("reset stall", {31'b0, bus.stall}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        chk("reset valid", {31'b0, bus.result_valid}, 32'd0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle stall", {31'b0, bus.stall}, 32'd0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div neg");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem neg");
        run_op(3'd5, 32'd100, 32'd7, "divu");
        run_op(3'd7, 32'd100, 32'd7, "remu");
        run_op(3'd4, 32'd5, 32'd0, "div by zero");
        run_op(3'd7, 32'd5, 32'd0, "remu by zero");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");

        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = 3'd4;
        bus.op_a = 32'd1000;
        bus.op_b = 32'd7;
        repeat (10) @(negedge clk);
        chk("busy before flush", {31'b0, bus.stall}, 32'd1);
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush stall", {31'b0, bus.stall}, 32'd0);
        chk("flush result kept", bus.result, last_res);
        for (int i = 0; i < 3; i++) begin
            chk("flush no valid", {31'b0, bus.result_valid}, 32'd0);
            @(negedge clk);
        end
        run_op(3'd5, 32'd9, 32'd3, "divu after flush");

        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.func3 = 3'd0;
        #1;
        chk("flush beats start", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        chk("no accept under flush", {31'b0, bus.stall}, 32'd0);
        chk("no valid under flush", {31'b0, bus.result_valid}, 32'd0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.func3 = 3'd0;
        bus.op_a = 32'd7;
        bus.op_b = 32'd3;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("stall in reset", {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("result after reset", bus.result, 32'd0);
        chk("valid after reset", {31'b0, bus.result_valid}, 32'd0);
        chk("reaccept stall", {31'b0, bus.stall}, 32'd1);
        await_done(32'd21, ML + 1, "mul reaccept");

        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 5) == 0 ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            run_op(f, a, b, $sformatf("rand%0d f%0d", i, f));
        end

        @(negedge clk);
        bus.start = 1'b0;
        chk("final no valid", {31'b0, bus.result_valid}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
